// File: rtl/mpt_mem_responder_pkg.sv
// rtl/mpt_mem_responder_pkg.sv - shared types and helpers for the MPT memory responder
// Purpose: response record carried through the latency pipeline and the byte-enable merge helper.
// Ports: none (package).
package mpt_mem_responder_pkg;

    localparam int MEM_DATA_WIDTH = 64;
    localparam int MEM_BE_WIDTH   = MEM_DATA_WIDTH / 8;

    typedef struct packed {
        logic                      valid;
        logic                      error;
        logic [MEM_DATA_WIDTH-1:0] rdata;
    } mem_rsp_t;

    // Replace each byte of old_word whose enable bit is set with the matching byte of wdata.
    function automatic logic [MEM_DATA_WIDTH-1:0] mem_byte_merge(
        input logic [MEM_DATA_WIDTH-1:0] old_word,
        input logic [MEM_DATA_WIDTH-1:0] wdata,
        input logic [MEM_BE_WIDTH-1:0]   be
    );
        logic [MEM_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MEM_BE_WIDTH; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mpt_mem_responder_if.sv
// rtl/mpt_mem_responder_if.sv - req/gnt/valid memory port bundle
// Purpose: groups the memory request and response signals of one MPT memory port.
// Ports: master drives req/addr/we/wdata/be and receives gnt/valid/rdata/error; slave is the mirror.
interface mpt_mem_responder_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    logic                    mem_req;
    logic                    mem_gnt;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic                    mem_valid;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_error;

    modport master (
        output mem_req, mem_addr, mem_we, mem_wdata, mem_be,
        input  mem_gnt, mem_valid, mem_rdata, mem_error
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_wdata, mem_be,
        output mem_gnt, mem_valid, mem_rdata, mem_error
    );
endinterface

// File: rtl/mpt_mem_responder_pipe.sv
// rtl/mpt_mem_responder_pipe.sv - fixed-latency in-order response pipeline
// Purpose: delays each accepted response by LATENCY cycles; the last stage holds error/rdata
//          between responses so the master sees stable values while valid is low.
// Ports: clk_i, rst_i (async active-high); i_rsp response entering at acceptance;
//        o_rsp response leaving; o_out_valid = o_rsp.valid for the grant retirement term.
module mpt_mem_responder_pipe
    import mpt_mem_responder_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  mem_rsp_t i_rsp,
    output mem_rsp_t o_rsp,
    output logic     o_out_valid
);

    mem_rsp_t r_stage [LATENCY];
    mem_rsp_t w_src   [LATENCY];

    assign w_src[0] = i_rsp;
    for (genvar g = 1; g < LATENCY; g++) begin : g_src
        assign w_src[g] = r_stage[g-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY - 1; i++) begin
                r_stage[i] <= w_src[i];
            end
            // Output stage only reloads payload on a real response.
            r_stage[LATENCY-1].valid <= w_src[LATENCY-1].valid;
            if (w_src[LATENCY-1].valid) begin
                r_stage[LATENCY-1].error <= w_src[LATENCY-1].error;
                r_stage[LATENCY-1].rdata <= w_src[LATENCY-1].rdata;
            end
        end
    end

    assign o_rsp       = r_stage[LATENCY-1];
    assign o_out_valid = r_stage[LATENCY-1].valid;

endmodule

// File: rtl/mpt_mem_responder.sv
// rtl/mpt_mem_responder.sv - word-addressed table store answering MPT memory requests
// Purpose: accepts one read/write per cycle, decodes and range-checks the byte address,
//          updates/reads the store, and returns in-order responses after LATENCY cycles
//          while limiting outstanding transactions to MAX_OUTSTANDING.
// Ports: clk_i clock; rst_i async active-high reset; stall_i forces gnt low;
//        memory_slave req/gnt/valid memory port (slave side).
module mpt_mem_responder
    import mpt_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH      = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH      = 64,
    parameter int DEPTH           = 256,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    mpt_mem_responder_if.slave  memory_slave
);

    localparam int OFF  = $clog2(DATA_WIDTH / 8);
    localparam int IDXW = $clog2(DEPTH);
    localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] STORE_BYTES = ADDR_WIDTH'(DEPTH * (DATA_WIDTH / 8));
    localparam logic [CNTW-1:0]       CNT_MAX     = CNTW'(MAX_OUTSTANDING);

    logic [DATA_WIDTH-1:0] r_store [DEPTH];
    logic [CNTW-1:0]       r_inflight;

    logic [IDXW-1:0] w_idx;
    logic            w_error;
    logic            w_gnt;
    logic            w_accept;
    logic            w_out_valid;
    mem_rsp_t        w_rsp_in;
    mem_rsp_t        w_rsp_out;

    assign w_idx   = memory_slave.mem_addr[OFF+IDXW-1:OFF];
    // Upper address bits take part only in the range compare.
    assign w_error = (|memory_slave.mem_addr[OFF-1:0]) || (memory_slave.mem_addr >= STORE_BYTES);

    // A response retiring this cycle frees a slot, so a full pipeline can still accept.
    assign w_gnt    = !rst_i && !stall_i && ((r_inflight < CNT_MAX) || w_out_valid);
    assign w_accept = memory_slave.mem_req && w_gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_accept && memory_slave.mem_we && !w_error) begin
            r_store[w_idx] <= mem_byte_merge(r_store[w_idx], memory_slave.mem_wdata, memory_slave.mem_be);
        end
    end

    always_comb begin
        w_rsp_in       = '0;
        w_rsp_in.valid = w_accept;
        w_rsp_in.error = w_accept && w_error;
        if (w_accept && !memory_slave.mem_we && !w_error) begin
            w_rsp_in.rdata = r_store[w_idx];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inflight <= '0;
        end else if (w_accept && !w_out_valid && (r_inflight < CNT_MAX)) begin
            r_inflight <= r_inflight + CNTW'(1);
        end else if (!w_accept && w_out_valid && (r_inflight != '0)) begin
            r_inflight <= r_inflight - CNTW'(1);
        end
    end

    mpt_mem_responder_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_rsp       (w_rsp_in),
        .o_rsp       (w_rsp_out),
        .o_out_valid (w_out_valid)
    );

    assign memory_slave.mem_gnt   = w_gnt;
    assign memory_slave.mem_valid = w_rsp_out.valid;
    assign memory_slave.mem_error = w_rsp_out.error;
    assign memory_slave.mem_rdata = w_rsp_out.rdata;

endmodule

// File: doc/mpt_mem_responder.md
Name: mpt_mem_responder

Overview:
- Memory-side responder for the MPT memory master port: the slave end of the req/gnt/valid protocol that the MPT walking and memory read stages drive.
- Holds a small word-addressed table store; accepts one read or write per cycle; returns in-order responses after a fixed latency.
- Enforces an outstanding-transaction limit and provides a grant-throttle input.
- Used as the table memory model in MPT subsystem benches and as on-chip table storage in small configurations.

Parameters:
- DATA_WIDTH, 64, memory word width in bits; power of two, at least 8.
- ADDR_WIDTH, 64, byte address width.
- DEPTH, 256, number of words in the store; power of two.
- LATENCY, 2, number of cycles from acceptance to response; at least 1.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions; from 1 to LATENCY.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- memory_slave_mem_req  in  1  request valid.
- memory_slave_mem_gnt  out  1  request accepted.
- memory_slave_mem_addr  in  ADDR_WIDTH  byte address.
- memory_slave_mem_we  in  1  1 = write, 0 = read.
- memory_slave_mem_wdata  in  DATA_WIDTH  write data.
- memory_slave_mem_be  in  DATA_WIDTH/8  byte enables.
- memory_slave_mem_valid  out  1  response valid (single-cycle pulse).
- memory_slave_mem_rdata  out  DATA_WIDTH  read data.
- memory_slave_mem_error  out  1  response carries an error.
- stall_i  in  1  forces gnt low (throttle and test hook).

Behaviour:
- Reset (asynchronous, active-high):
  - gnt, valid, error = 0; rdata = 0.
  - Response pipeline and in-flight counter cleared.
  - Store zeroed.
  - Any transaction in flight when reset asserts is dropped; no response is produced for it.
- Grant:
  - gnt = !stall_i && (inflight < MAX_OUTSTANDING), plus the pipeline retirement rule below.
  - gnt does not depend on req.
  - Acceptance occurs when req && gnt are both high at a rising edge.
- Address decode:
  - OFF = log2(DATA_WIDTH/8).
  - Word index = addr[OFF+log2(DEPTH)-1 : OFF].
  - Error when addr[OFF-1:0] != 0 or addr >= DEPTH*DATA_WIDTH/8.
- Access at acceptance edge:
  - Write without error: each byte i of the store word is updated from wdata where be[i] = 1. be = 0 is legal and is a no-op with a normal response.
  - Read without error: the store word is captured into the response pipeline.
  - Any error: no store update; response has rdata = 0 and error = 1.
  - Write response: rdata = 0, error = 0.
- Ordering: a read accepted at cycle t+1 sees a write accepted at cycle t. Reads observe all previously accepted writes.
- Response timing:
  - valid pulses exactly LATENCY cycles after acceptance, in acceptance order.
  - At most one response per cycle, guaranteed by one acceptance per cycle.
  - No backpressure on responses; the master must sink them.
  - rdata and error hold their last values while valid = 0.
- In-flight counter:
  - +1 on acceptance, -1 on valid; unchanged when both occur in the same cycle.
  - Saturates: never exceeds MAX_OUTSTANDING and never underflows.
- Full throughput: with MAX_OUTSTANDING = LATENCY, a back-to-back req stream is granted every cycle, because gnt includes the case where a response retires in the same cycle.
  - gnt = !stall_i && (inflight < MAX_OUTSTANDING || pipeline-output valid this cycle).
- stall_i high mid-stream: no new acceptances; responses already in flight still complete on schedule.
- Width rules: be width is DATA_WIDTH/8. Address bits above the range check are only compared, never indexed.

Decomposition:
- mpt_pkg gains:
  - mem_rsp_t struct {logic valid; logic error; logic [DATA_WIDTH-1:0] rdata}, parameterised via a localparam width.
  - Function mem_byte_merge(old, wdata, be).
- Sub-module mem_response_pipe:
  - LATENCY-deep shift register of mem_rsp_t, reset to zero.
  - Exposes out_valid for the grant-retirement term.
- Top level holds the store, decode, counter and grant logic.

Test Plan:
1. Reset, then write addr 0x10, wdata 0xDEADBEEF_CAFEF00D, be 0xFF, then read 0x10. Write response: valid at +2, error 0. Read response: rdata 0xDEADBEEF_CAFEF00D at +2.
2. Partial write to 0x10 with be 0x0F, wdata 0x11111111_22222222, after test 1. Read 0x10 returns 0xDEADBEEF_22222222.
3. Back-to-back reads at 0x0, 0x8, 0x10, 0x18 over 4 cycles with MAX_OUTSTANDING = 2. gnt high every cycle; valid on 4 consecutive cycles, in order.
4. Set MAX_OUTSTANDING = 1 and issue continuous req. gnt alternates 1/0 in steady state; each response arrives 2 cycles after its grant.
5. Read addr 0x0C (misaligned) and addr 0x800 (out of range). Both responses: error 1, rdata 0; store unchanged.
6. Assert rst_i one cycle after accepting a read, release it, then hold stall_i = 1 with req = 1. No valid appears for the dropped read; gnt stays 0 while stall_i = 1, then goes 1 the cycle after stall_i is released.
